// File: rtl/lagarto_pmu_counters.sv
// Performance-monitor counter bank for the Lagarto tile: one wrapping counter per pmu_sig event,
// sticky overflow flags, level overflow interrupt and a single-cycle register access port.
module lagarto_pmu_counters #(
  parameter int NUM_EVENTS = 23,
  parameter int CNT_W      = 48,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVENTS-1:0] pmu_sig_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [63:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [63:0]           rdata_o,
  output logic                  err_o,
  output logic                  ovf_irq_o
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL  = ADDR_W'(32'h20);
  localparam logic [ADDR_W-1:0] ADDR_EN    = ADDR_W'(32'h21);
  localparam logic [ADDR_W-1:0] ADDR_OVF   = ADDR_W'(32'h22);
  localparam logic [ADDR_W-1:0] ADDR_CLEAR = ADDR_W'(32'h23);

  logic [CNT_W-1:0]      cnt_q   [NUM_EVENTS];
  logic [CNT_W-1:0]      cnt_nxt [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ev_p1;
  logic [NUM_EVENTS-1:0] ovf_q, ovf_nxt, wrap, inc;
  logic [NUM_EVENTS-1:0] en_mask_q;
  logic [1:0]            ctrl_q;

  logic                  rvalid_p1, err_p1;
  logic [63:0]           rdata_p1;

  logic                  wr, clr, w1c, is_cnt, unmapped;
  logic [63:0]           rd_val;

  assign wr     = req_i & we_i;
  assign clr    = wr & (addr_i == ADDR_CLEAR);
  assign w1c    = wr & (addr_i == ADDR_OVF);
  assign is_cnt = 32'(addr_i) < 32'(NUM_EVENTS);

  // Counter next-state: CLEAR beats a direct write, which in turn swallows that cycle's increment
  always_comb begin
    wrap = '0;
    inc  = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      inc[i]     = ctrl_q[0] & en_mask_q[i] & ev_p1[i];
      cnt_nxt[i] = cnt_q[i];
      if (clr) begin
        cnt_nxt[i] = '0;
      end else if (wr && addr_i == ADDR_W'(i)) begin
        cnt_nxt[i] = wdata_i[CNT_W-1:0];
      end else if (inc[i]) begin
        cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        wrap[i]    = &cnt_q[i];
      end
    end
    // A wrap on the same edge as a W1C keeps the flag set; CLEAR overrides both
    if (clr) ovf_nxt = '0;
    else     ovf_nxt = (ovf_q & ~(w1c ? wdata_i[NUM_EVENTS-1:0] : '0)) | wrap;
  end

  always_comb begin
    rd_val   = '0;
    unmapped = 1'b0;
    case (addr_i)
      ADDR_CTRL:  rd_val = 64'(ctrl_q);
      ADDR_EN:    rd_val = 64'(en_mask_q);
      ADDR_OVF:   rd_val = 64'(ovf_q);
      ADDR_CLEAR: rd_val = '0;
      default: begin
        unmapped = ~is_cnt;
        for (int i = 0; i < NUM_EVENTS; i++)
          if (addr_i == ADDR_W'(i)) rd_val = 64'(cnt_q[i]);
      end
    endcase
  end

  // Stage p1: event capture, architectural state update and registered response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
      ev_p1     <= '0;
      ovf_q     <= '0;
      en_mask_q <= '1;
      ctrl_q    <= '0;
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
      err_p1    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= cnt_nxt[i];
      ev_p1     <= pmu_sig_i;
      ovf_q     <= ovf_nxt;
      if (wr && addr_i == ADDR_CTRL) ctrl_q    <= wdata_i[1:0];
      if (wr && addr_i == ADDR_EN)   en_mask_q <= wdata_i[NUM_EVENTS-1:0];
      rvalid_p1 <= req_i;
      rdata_p1  <= (req_i && !we_i) ? rd_val : '0;
      err_p1    <= req_i & unmapped;
    end
  end

  assign rvalid_o  = rvalid_p1;
  assign rdata_o   = rdata_p1;
  assign err_o     = err_p1;
  assign ovf_irq_o = ctrl_q[1] & |(ovf_q & en_mask_q);

endmodule

// File: tb/tb_lagarto_pmu_counters.sv
// Scoreboard bench for lagarto_pmu_counters: a reference model predicts every response, a monitor
// checks what the DUT returns; directed scenarios followed by randomized traffic.
module tb_lagarto_pmu_counters;
  localparam int N = 23;
  localparam logic [47:0] CMAX = '1;

  logic        clk = 1'b0, rst_ni = 1'b0;
  logic [N-1:0] sig = '0;
  logic        req = 1'b0, we = 1'b0;
  logic [5:0]  addr = '0;
  logic [63:0] wdata = '0;
  logic        rvalid, err, irq;
  logic [63:0] rdata;

  always #5 clk = ~clk;

  lagarto_pmu_counters #(.NUM_EVENTS(N), .CNT_W(48), .ADDR_W(6)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pmu_sig_i(sig), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .ovf_irq_o(irq)
  );

  typedef struct {int due; logic [63:0] rd; logic er;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: architectural state as plain arrays
  logic [47:0] m_cnt [N];
  logic [N-1:0] m_ovf, m_en, m_ev;
  logic [1:0]  m_ctrl;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    m_ovf = '0; m_en = '1; m_ev = '0; m_ctrl = '0;
  endtask

  function automatic logic model_irq();
    return m_ctrl[1] && |(m_ovf & m_en);
  endfunction

  function automatic logic [64:0] model_read(input logic [5:0] a);
    if (a < 6'd23) return {1'b0, 16'b0, m_cnt[a[4:0]]};
    case (a)
      6'h20:   return {1'b0, 62'b0, m_ctrl};
      6'h21:   return {1'b0, 41'b0, m_en};
      6'h22:   return {1'b0, 41'b0, m_ovf};
      6'h23:   return '0;
      default: return {1'b1, 64'b0};
    endcase
  endfunction

  task automatic model_edge(input bit rq, input bit w, input logic [5:0] a,
                            input logic [63:0] wd, input logic [N-1:0] s);
    logic [N-1:0] wraps;
    bit clr;
    wraps = '0;
    clr = rq && w && a == 6'h23;
    for (int i = 0; i < N; i++) begin
      if (clr) m_cnt[i] = '0;
      else if (rq && w && a == i) m_cnt[i] = wd[47:0];
      else if (m_ctrl[0] && m_en[i] && m_ev[i]) begin
        if (m_cnt[i] == CMAX) wraps[i] = 1'b1;
        m_cnt[i] = m_cnt[i] + 48'd1;
      end
    end
    if (clr) m_ovf = '0;
    else begin
      if (rq && w && a == 6'h22) m_ovf = m_ovf & ~wd[N-1:0];
      m_ovf = m_ovf | wraps;
    end
    if (rq && w && a == 6'h20) m_ctrl = wd[1:0];
    if (rq && w && a == 6'h21) m_en = wd[N-1:0];
    m_ev = s;
  endtask

  // One clock edge of stimulus; the expected response is queued for the monitor
  task automatic step(input bit rq, input bit w, input logic [5:0] a, input logic [63:0] wd,
                      input logic [N-1:0] s, input bit fixed = 0,
                      input logic [63:0] frd = '0, input bit fer = 0);
    logic [64:0] r;
    exp_t e;
    @(negedge clk);
    req = rq; we = w; addr = a; wdata = wd; sig = s;
    if (rq) begin
      r = model_read(a);
      e.due = cyc + 1;
      e.rd  = fixed ? frd : (w ? 64'd0 : r[63:0]);
      e.er  = fixed ? fer : r[64];
      q.push_back(e);
    end
    model_edge(rq, w, a, wd, s);
    @(posedge clk);
    #1;
    req = 0; we = 0; addr = '0; wdata = '0; sig = '0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [63:0] d);
    step(1, 1, a, d, 23'h1);
  endtask

  task automatic rdc(input logic [5:0] a, input logic [63:0] v, input bit e = 0);
    step(1, 0, a, '0, 23'h1, 1, v, e);
  endtask

  task automatic idle(input int n, input logic [N-1:0] s = 23'h1);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, s);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (rst_ni) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (rvalid || ev) begin
        chk("rvalid", 64'(rvalid), 64'(ev));
        if (ev) begin
          e = q.pop_front();
          if (rvalid) begin
            chk("rdata", rdata, e.rd);
            chk("err", 64'(err), 64'(e.er));
          end
        end
      end
    end
  end

  initial begin
    logic [5:0]  a;
    logic [63:0] d;
    bit rq, w;
    int sel;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rvalid", 64'(rvalid), 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_err", 64'(err), 0);
    chk("reset_irq", 64'(irq), 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Idle counting: only the cycle counter moves
    wr(6'h20, 64'd1);
    idle(100);
    for (int i = 1; i < N; i++) rdc(6'(i), 64'd0);
    rdc(6'h3F, 64'd0, 1);
    rdc(6'h17, 64'd0, 1);
    wr(6'h30, 64'hDEAD);

    // Ten pulses on event 5, then masked off
    wr(6'h23, 64'd0);
    idle(10, 23'h21);
    idle(3);
    rdc(6'h05, 64'd10);
    wr(6'h21, 64'h7FFFDF);
    idle(10, 23'h21);
    idle(3);
    rdc(6'h05, 64'd10);
    wr(6'h21, 64'h7FFFFF);

    // Wrap of counter 7 sets OVF and raises the interrupt
    wr(6'h07, 64'h0000_FFFF_FFFF_FFFE);
    wr(6'h20, 64'd3);
    idle(3, 23'h81);
    idle(3);
    rdc(6'h07, 64'd1);
    rdc(6'h22, 64'h80);
    chk("irq_set", 64'(irq), 1);
    wr(6'h22, 64'h80);
    chk("irq_clr", 64'(irq), 0);

    // Direct write beats increment; wrap beats W1C
    idle(1, 23'h9);
    wr(6'h03, 64'd100);
    idle(2);
    rdc(6'h03, 64'd100);
    step(1, 1, 6'h03, '1, 23'h9);
    wr(6'h22, 64'h8);
    rdc(6'h22, 64'h8);
    rdc(6'h03, 64'd0);
    chk("irq_w1c_lost", 64'(irq), 1);
    wr(6'h22, 64'h7FFFFF);

    // Back-to-back reads
    step(1, 0, 6'h00, '0, 23'h1);
    step(1, 0, 6'h20, '0, 23'h1);
    rdc(6'h21, 64'h7FFFFF);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rq  = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      d   = {$urandom, $urandom};
      if (sel <= 4) begin
        a = 6'($urandom_range(0, N - 1));
        if ($urandom_range(0, 1) == 1) d = 64'h0000_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      end else if (sel == 5) begin
        a = 6'h20;
        d = 64'($urandom_range(1, 3));
      end else if (sel == 6) a = 6'h21;
      else if (sel == 7) a = 6'h22;
      else if (sel == 8) a = ($urandom_range(0, 7) == 0) ? 6'h23 : 6'h00;
      else a = 6'($urandom);
      step(rq, w, a, d, N'($urandom) | 23'h1);
      chk("irq_rand", 64'(irq), 64'(model_irq()));
    end

    // Asynchronous reset while counting with a response in flight
    wr(6'h20, 64'd1);
    idle(5, 23'h7FFFFF);
    step(1, 0, 6'h05, '0, 23'h7FFFFF);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_rvalid", 64'(rvalid), 0);
    q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    rdc(6'h05, 64'd0);
    rdc(6'h16, 64'd0);
    rdc(6'h21, 64'h7FFFFF);
    rdc(6'h20, 64'd0);
    rdc(6'h22, 64'd0);
    idle(3);
    chk("queue_empty", 64'(q.size()), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
